// File: rtl/fpu_lib_pkg.sv
// fpu_lib: shared types and constants for the fpu16 flag/status CSR block.
//   statusFlag_t   - packed exception flags, MSB..LSB = NV, DZ, OF, UF, NX
//   FLAG_*         - bit index of each flag inside statusFlag_t
//   csrAddr_t      - CSR register select encoding
//   CTRL_*_BIT     - special bit positions in the CTRL register
//   cnt_flag_idx() - maps a counter CSR address to its flag bit index
package fpu_lib;

    localparam int NUM_FLAGS = 5;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int CTRL_CNTCLR_BIT = 8;
    localparam int CTRL_CNTEN_BIT  = 9;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } statusFlag_t;

    typedef enum logic [2:0] {
        CSR_FFLAGS    = 3'd0,
        CSR_FFLAGS_RC = 3'd1,
        CSR_CTRL      = 3'd2,
        CSR_CNT_NV    = 3'd3,
        CSR_CNT_DZ    = 3'd4,
        CSR_CNT_OF    = 3'd5,
        CSR_CNT_UF    = 3'd6,
        CSR_CNT_NX    = 3'd7
    } csrAddr_t;

    // Counter registers run NV..NX at addresses 3..7 while flag bits run
    // NV..NX at indices 4..0, so the flag index is 7 - address.
    function automatic logic [2:0] cnt_flag_idx(input csrAddr_t addr);
        logic [2:0] idx;
        idx = 3'd7 - 3'(addr);
        return idx;
    endfunction

endpackage

// File: rtl/fpu_sat_counter.sv
// fpu_sat_counter: CNT_W-bit saturating event counter.
//   clock, reset - clock and synchronous active-high reset
//   inc_i        - count one event this cycle
//   clr_i        - clear to zero this cycle (applied before inc_i)
//   count_o      - registered count, sticks at all-ones
module fpu_sat_counter
    import fpu_lib::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] base_s;

    // Next count: clear first, then a saturating increment on the cleared value.
    always_comb begin
        base_s  = count_q;
        count_d = count_q;
        if (clr_i) begin
            base_s = {CNT_W{1'b0}};
        end else begin
            base_s = count_q;
        end
        if (inc_i && (base_s != {CNT_W{1'b1}})) begin
            count_d = base_s + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = base_s;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fpu_flag_csr.sv
// fpu_flag_csr: sticky fflags accumulator, per-flag event counters and a
// maskable level interrupt for the fpu16 status interface, behind a
// req/ack CSR port with a fixed one-cycle acknowledge.
//   clock, reset  - clock and synchronous active-high reset
//   fpuDone       - completion pulse qualifying statusFlags
//   statusFlags   - flags of the completing operation
//   csrReq/csrWrite/csrAddr/csrWData - CSR request (strobe, dir, select, data)
//   csrAck        - registered acknowledge, one cycle after csrReq
//   csrRData      - read data valid with csrAck, zero otherwise
//   flagIrq       - registered |(fflags & irqMask)
module fpu_flag_csr
    import fpu_lib::*;
#(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fpuDone,
    input  statusFlag_t       statusFlags,
    input  logic              csrReq,
    input  logic              csrWrite,
    input  logic [2:0]        csrAddr,
    input  logic [DATA_W-1:0] csrWData,
    output logic              csrAck,
    output logic [DATA_W-1:0] csrRData,
    output logic              flagIrq
);

    logic [NUM_FLAGS-1:0] fflags_q,   fflags_d;
    logic [NUM_FLAGS-1:0] irq_mask_q, irq_mask_d;
    logic                 count_en_q, count_en_d;
    logic                 ack_q,      ack_d;
    logic [DATA_W-1:0]    rdata_q,    rdata_d;
    logic                 irq_q,      irq_d;

    logic [NUM_FLAGS-1:0] flags_s;
    logic [NUM_FLAGS-1:0] fflags_base_s;
    logic [NUM_FLAGS-1:0] cnt_inc_s;
    logic                 cnt_clr_s;
    logic                 wr_s;
    logic                 rd_s;
    csrAddr_t             addr_s;
    logic [CNT_W-1:0]     cnt_s [NUM_FLAGS];

    assign flags_s = statusFlags;
    assign addr_s  = csrAddr_t'(csrAddr);
    assign wr_s    = csrReq &  csrWrite;
    assign rd_s    = csrReq & ~csrWrite;

    // CSR side effects and flag capture; CSR write/clear forms the base so
    // flags from a same-cycle completion are ORed in afterwards and never lost.
    always_comb begin
        fflags_base_s = fflags_q;
        irq_mask_d    = irq_mask_q;
        count_en_d    = count_en_q;
        cnt_clr_s     = 1'b0;
        if (wr_s && (addr_s == CSR_FFLAGS)) begin
            fflags_base_s = csrWData[NUM_FLAGS-1:0];
        end else if (rd_s && (addr_s == CSR_FFLAGS_RC)) begin
            fflags_base_s = {NUM_FLAGS{1'b0}};
        end else begin
            fflags_base_s = fflags_q;
        end
        if (wr_s && (addr_s == CSR_CTRL)) begin
            irq_mask_d = csrWData[NUM_FLAGS-1:0];
            count_en_d = csrWData[CTRL_CNTEN_BIT];
            cnt_clr_s  = csrWData[CTRL_CNTCLR_BIT];
        end else begin
            irq_mask_d = irq_mask_q;
            count_en_d = count_en_q;
            cnt_clr_s  = 1'b0;
        end
        if (fpuDone) begin
            fflags_d = fflags_base_s | flags_s;
        end else begin
            fflags_d = fflags_base_s;
        end
        irq_d = |(fflags_d & irq_mask_d);
    end

    // Increment gating uses the countEn value in force during the event.
    assign cnt_inc_s = (fpuDone && count_en_q) ? flags_s : {NUM_FLAGS{1'b0}};

    // Read mux: sees pre-update state; write acks return zero.
    always_comb begin
        ack_d   = csrReq;
        rdata_d = {DATA_W{1'b0}};
        if (rd_s) begin
            case (addr_s)
                CSR_FFLAGS, CSR_FFLAGS_RC: rdata_d = DATA_W'(fflags_q);
                CSR_CTRL: begin
                    rdata_d = DATA_W'(irq_mask_q);
                    rdata_d[CTRL_CNTEN_BIT] = count_en_q;
                end
                CSR_CNT_NV, CSR_CNT_DZ, CSR_CNT_OF, CSR_CNT_UF, CSR_CNT_NX:
                    rdata_d = DATA_W'(cnt_s[cnt_flag_idx(addr_s)]);
                default: rdata_d = {DATA_W{1'b0}};
            endcase
        end else begin
            rdata_d = {DATA_W{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fflags_q   <= {NUM_FLAGS{1'b0}};
            irq_mask_q <= {NUM_FLAGS{1'b0}};
            count_en_q <= 1'b1;
            ack_q      <= 1'b0;
            rdata_q    <= {DATA_W{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            fflags_q   <= fflags_d;
            irq_mask_q <= irq_mask_d;
            count_en_q <= count_en_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_cnt
        fpu_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clock   (clock),
            .reset   (reset),
            .inc_i   (cnt_inc_s[g]),
            .clr_i   (cnt_clr_s),
            .count_o (cnt_s[g])
        );
    end

    assign csrAck   = ack_q;
    assign csrRData = rdata_q;
    assign flagIrq  = irq_q;

endmodule

// File: tb/tb_fpu_flag_csr.sv
// Scoreboard bench for fpu_flag_csr: each CSR request pushes its expected
// read data; a negedge monitor checks ack timing and pops/compares data.
module tb_fpu_flag_csr;
    import fpu_lib::*;

    localparam int CNT_W  = 4;
    localparam int DATA_W = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              fpuDone;
    statusFlag_t       statusFlags;
    logic              csrReq;
    logic              csrWrite;
    logic [2:0]        csrAddr;
    logic [DATA_W-1:0] csrWData;
    logic              csrAck;
    logic [DATA_W-1:0] csrRData;
    logic              flagIrq;

    int n_vec  = 0;
    int n_miss = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic exp_ack = 1'b0;

    fpu_flag_csr #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .fpuDone     (fpuDone),
        .statusFlags (statusFlags),
        .csrReq      (csrReq),
        .csrWrite    (csrWrite),
        .csrAddr     (csrAddr),
        .csrWData    (csrWData),
        .csrAck      (csrAck),
        .csrRData    (csrRData),
        .flagIrq     (flagIrq)
    );

    always #5 clock = ~clock;

    // Expected ack: a request accepted at an edge without reset.
    always @(posedge clock) exp_ack <= csrReq && !reset;

    // Monitor: ack timing and read data.
    always @(negedge clock) begin
        if (csrAck || exp_ack) begin
            n_vec++;
            if (csrAck !== exp_ack) begin
                n_miss++;
                $display("FAIL ack_timing: got %0b expected %0b", csrAck, exp_ack);
            end
        end
        if (csrAck) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL rdata_unexpected_ack: got 0x%04h, no expected entry", csrRData);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (csrRData !== e) begin
                    n_miss++;
                    $display("FAIL rdata: got 0x%04h expected 0x%04h", csrRData, e);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
        csrReq   = 1'b0;
        csrWrite = 1'b0;
        fpuDone  = 1'b0;
        statusFlags = 5'b00000;
    endtask

    task automatic set_rd(input logic [2:0] a, input logic [DATA_W-1:0] e);
        csrReq = 1'b1; csrWrite = 1'b0; csrAddr = a;
        exp_q.push_back(e);
    endtask

    task automatic set_wr(input logic [2:0] a, input logic [DATA_W-1:0] d);
        csrReq = 1'b1; csrWrite = 1'b1; csrAddr = a; csrWData = d;
        exp_q.push_back(16'h0000);
    endtask

    task automatic rd(input logic [2:0] a, input logic [DATA_W-1:0] e);
        set_rd(a, e);
        cycle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [DATA_W-1:0] d);
        set_wr(a, d);
        cycle();
    endtask

    task automatic fpu(input logic [4:0] f);
        fpuDone = 1'b1; statusFlags = f;
        cycle();
    endtask

    task automatic chk_irq(input string name, input logic e);
        n_vec++;
        if (flagIrq !== e) begin
            n_miss++;
            $display("FAIL %s: flagIrq got %0b expected %0b", name, flagIrq, e);
        end
    endtask

    initial begin
        reset = 1'b1; fpuDone = 1'b0; statusFlags = 5'b00000;
        csrReq = 1'b0; csrWrite = 1'b0; csrAddr = 3'd0; csrWData = 16'h0000;
        cycle(); cycle();
        reset = 1'b0;
        chk_irq("reset_irq", 1'b0);

        // 1: reset values
        rd(3'd0, 16'h0000);
        rd(3'd2, 16'h0200);
        rd(3'd3, 16'h0000);
        cycle();

        // 2: accumulate and count
        fpu(5'b10000);
        fpu(5'b01001);
        fpu(5'b00000);
        rd(3'd0, 16'h0019);
        rd(3'd3, 16'h0001);
        rd(3'd4, 16'h0001);
        rd(3'd7, 16'h0001);
        rd(3'd5, 16'h0000);
        rd(3'd6, 16'h0000);

        // 3: read-and-clear with same-cycle capture
        wr(3'd0, 16'h0010);
        set_rd(3'd1, 16'h0010);
        fpuDone = 1'b1; statusFlags = 5'b00100;
        cycle();
        rd(3'd0, 16'h0004);
        rd(3'd5, 16'h0001);
        wr(3'd1, 16'h001F);
        rd(3'd0, 16'h0004);

        // 4: interrupt latency
        wr(3'd2, 16'h0201);
        rd(3'd2, 16'h0201);
        chk_irq("irq_masked_off", 1'b0);
        fpu(5'b00001);
        chk_irq("irq_rise", 1'b1);
        wr(3'd0, 16'h0000);
        chk_irq("irq_fall", 1'b0);
        rd(3'd7, 16'h0002);

        // 5: saturation and clear-then-inc
        for (int i = 0; i < 20; i++) fpu(5'b10000);
        rd(3'd3, 16'h000F);
        set_wr(3'd2, 16'h0301);
        fpuDone = 1'b1; statusFlags = 5'b10000;
        cycle();
        rd(3'd3, 16'h0001);
        rd(3'd7, 16'h0000);
        rd(3'd2, 16'h0201);

        // 6: counting disabled, then reset drops pending ack
        wr(3'd2, 16'h0000);
        rd(3'd2, 16'h0000);
        fpu(5'b11111);
        rd(3'd0, 16'h001F);
        rd(3'd3, 16'h0001);
        rd(3'd4, 16'h0000);
        rd(3'd7, 16'h0000);
        csrReq = 1'b1; csrWrite = 1'b0; csrAddr = 3'd0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk_irq("irq_after_reset", 1'b0);
        rd(3'd0, 16'h0000);
        rd(3'd2, 16'h0200);
        rd(3'd3, 16'h0000);
        rd(3'd6, 16'h0000);
        repeat (3) cycle();

        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL missing_acks: %0d expected responses never arrived", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
